dmem_console: RTL and testbench

- Synthesizable memory-mapped console responder on the core's data-memory port. Replaces the simulation-only PUTC/EXIT decode, so programs run the same way on FPGA.
- The core is the initiator. This block is the responder: it accepts stores to the PUTC and EXIT addresses, queues console bytes in a FIFO and serializes them on an 8N1 UART line.
- It also exposes a readable status register.

---
 rtl/dmem_console_if.sv | 22 ++
 rtl/dmem_console.sv | 165 ++++++++++++++++
 tb/tb_dmem_console.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_console_if.sv
// Data-memory port between the core (master) and the console responder (slave).
interface dmem_console_if;
  logic        dmem_rready;
  logic [31:0] dmem_raddr;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic        dmem_wready;
  logic [31:0] dmem_waddr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_wvalid;

  modport master (
    output dmem_rready, dmem_raddr, dmem_wready, dmem_waddr, dmem_wdata, dmem_wstrb,
    input  dmem_rdata, dmem_rvalid, dmem_wvalid
  );

  modport slave (
    input  dmem_rready, dmem_raddr, dmem_wready, dmem_waddr, dmem_wdata, dmem_wstrb,
    output dmem_rdata, dmem_rvalid, dmem_wvalid
  );
endinterface

// File: rtl/dmem_console.sv
// MMIO console responder: PUTC bytes go through a TX FIFO to an 8N1 UART line,
// EXIT latches the program's exit code, STATUS reports FIFO/serializer/exit state.
module dmem_console #(
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CLKDIV = 868
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_console_if.slave        dmem,
  output logic                 uart_tx,
  output logic                 exit_valid,
  output logic [31:0]          exit_code
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(CLKDIV);
  localparam logic [TW-1:0] TMax = TW'(CLKDIV - 1);

  localparam logic [31:0] AddrPutc   = BASE + 32'h1c;
  localparam logic [31:0] AddrStatus = BASE + 32'h20;
  localparam logic [31:0] AddrExit   = BASE + 32'h2c;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, level;
  logic          full, empty, push, pop, wr_acc;
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [31:0]   rdata_q, rdata_d, status;
  logic          exit_valid_q, exit_valid_d;
  logic [31:0]   exit_code_q, exit_code_d;
  logic [7:0]    level8;
  logic          unused_strb;

  assign unused_strb = ^dmem.dmem_wstrb[3:1];

  assign level = wptr_q - rptr_q;
  assign full  = (level == PW'(DEPTH));
  assign empty = (level == '0);
  assign level8 = 8'(level);

  // Full is checked before any same-cycle pop, so a PUTC to a full FIFO always stalls.
  assign dmem.dmem_wvalid = !((dmem.dmem_waddr == AddrPutc) && full);
  assign dmem.dmem_rvalid = 1'b1;
  assign wr_acc = dmem.dmem_wready && dmem.dmem_wvalid;
  assign push   = wr_acc && (dmem.dmem_waddr == AddrPutc) && dmem.dmem_wstrb[0];

  assign status = {16'b0, level8, 5'b0, exit_valid_q, empty && (state_q == StIdle), full};

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q[AW-1:0]];
          timer_d = TMax;
          state_d = StStart;
        end
      end
      StStart: begin
        if (timer_q == '0) begin
          timer_d = TMax;
          bit_d   = 3'd0;
          state_d = StData;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StData: begin
        if (timer_q == '0) begin
          timer_d = TMax;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        if (timer_q == '0) begin
          // Back-to-back frames: reload straight into START without an idle cycle.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q[AW-1:0]];
            timer_d = TMax;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
    endcase

    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    wptr_d       = wptr_q + PW'(push);
    rptr_d       = rptr_q + PW'(pop);
    rdata_d      = rdata_q;
    exit_valid_d = exit_valid_q;
    exit_code_d  = exit_code_q;
    if (dmem.dmem_rready) begin
      rdata_d = (dmem.dmem_raddr == AddrStatus) ? status : 32'h0;
    end
    if (wr_acc && (dmem.dmem_waddr == AddrExit) && !exit_valid_q) begin
      exit_valid_d = 1'b1;
      exit_code_d  = dmem.dmem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= dmem.dmem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      state_q      <= StIdle;
      timer_q      <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      rdata_q      <= '0;
      exit_valid_q <= 1'b0;
      exit_code_q  <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      rdata_q      <= rdata_d;
      exit_valid_q <= exit_valid_d;
      exit_code_q  <= exit_code_d;
    end
  end

  assign dmem.dmem_rdata = rdata_q;
  assign uart_tx         = tx_q;
  assign exit_valid      = exit_valid_q;
  assign exit_code       = exit_code_q;
endmodule

// File: tb/tb_dmem_console.sv
// Bench for dmem_console: expected console bytes are queued on PUTC acceptance and
// a line monitor decodes 8N1 frames off uart_tx and checks them against the queue.
module tb_dmem_console;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int CD = 4;
  localparam int DEP = 4;
  localparam logic [31:0] PUTC = BASE + 32'h1c;
  localparam logic [31:0] STAT = BASE + 32'h20;
  localparam logic [31:0] EXIT = BASE + 32'h2c;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_tx, exit_valid;
  logic [31:0] exit_code;

  dmem_console_if bus ();

  dmem_console #(.BASE(BASE), .DEPTH(DEP), .CLKDIV(CD)) dut (
    .clk       (clk),
    .reset     (reset),
    .dmem      (bus),
    .uart_tx   (uart_tx),
    .exit_valid(exit_valid),
    .exit_code (exit_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int         start_edges[$];
  int         frames_seen = 0;
  bit         mon_busy = 1'b0;
  bit         m_exit = 1'b0;
  logic [31:0] m_code = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Line monitor: ph counts negedges since the first low sample of a frame.
  initial begin
    int ph = 0;
    logic [7:0] b = 8'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_busy = 1'b0;
      end else if (!mon_busy) begin
        if (uart_tx === 1'b0) begin
          mon_busy = 1'b1;
          ph = 0;
          start_edges.push_back(cyc + 1);
        end
      end else begin
        ph++;
        if (ph == CD / 2) chk("start_bit", {31'b0, uart_tx}, 32'd0);
        for (int i = 0; i < 8; i++) if (ph == CD * (i + 1) + CD / 2) b[i] = uart_tx;
        if (ph == 9 * CD + CD / 2) chk("stop_bit", {31'b0, uart_tx}, 32'd1);
        if (ph == 10 * CD - 1) begin
          mon_busy = 1'b0;
          frames_seen++;
          if (exp_q.size() == 0) chk("unexpected_frame", {24'b0, b}, 32'hxxxx_xxxx);
          else chk("frame_byte", {24'b0, b}, {24'b0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    output int acc);
    int n = 0;
    bit done = 1'b0;
    bus.dmem_waddr = a; bus.dmem_wdata = d; bus.dmem_wstrb = s; bus.dmem_wready = 1'b1;
    while (!done && n < 300) begin
      @(negedge clk);
      if (bus.dmem_wvalid === 1'b1) done = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    bus.dmem_wready = 1'b0;
    acc = cyc;
    if (!done) begin
      checks++; errors++;
      $display("FAIL write_timeout: addr %h not accepted in %0d cycles", a, n);
    end else begin
      if (a == PUTC && s[0]) exp_q.push_back(d[7:0]);
      if (a == EXIT && !m_exit) begin m_exit = 1'b1; m_code = d; end
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus.dmem_rready = 1'b1; bus.dmem_raddr = a;
    @(posedge clk); #1;
    bus.dmem_rready = 1'b0;
    v = bus.dmem_rdata;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 20000) begin @(posedge clk); #1; n++; end
    chk("drain_done", {31'b0, n < 20000}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] idle_status();
    return {29'b0, m_exit, 2'b10};
  endfunction

  initial begin
    int a0, a1, acc[6], fr;
    logic [31:0] v;
    bus.dmem_rready = 1'b0; bus.dmem_raddr = '0; bus.dmem_wready = 1'b0;
    bus.dmem_waddr = '0; bus.dmem_wdata = '0; bus.dmem_wstrb = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset and idle status
    chk("reset_tx", {31'b0, uart_tx}, 32'd1);
    chk("reset_exit_valid", {31'b0, exit_valid}, 32'd0);
    chk("reset_rdata", bus.dmem_rdata, 32'd0);
    chk("rvalid", {31'b0, bus.dmem_rvalid}, 32'd1);
    bus.dmem_waddr = PUTC; #1;
    chk("idle_wvalid", {31'b0, bus.dmem_wvalid}, 32'd1);
    rd(STAT, v); chk("idle_status", v, 32'h2);

    // Single 'A' frame and its latency
    wr(PUTC, 32'h41, 4'b0001, a0);
    drain();
    chk("a_latency", start_edges[start_edges.size() - 1] - a0, 32'd2);
    rd(STAT, v); chk("status_after_a", v, 32'h2);

    // Burst into a 4-deep FIFO with backpressure on the sixth write
    for (int i = 0; i < 5; i++) wr(PUTC, 32'h30 + i, 4'b0001, acc[i]);
    rd(STAT, v); chk("burst_full_status", v, 32'h0000_0401);
    wr(PUTC, 32'h35, 4'b0001, acc[5]);
    chk("burst_consec", acc[4] - acc[0], 32'd4);
    chk("sixth_accept", acc[5] - acc[0], 32'd42);
    drain();
    for (int i = 1; i < 6; i++)
      chk("no_gap", start_edges[start_edges.size() - 6 + i] - start_edges[start_edges.size() - 7 + i],
          32'd40);

    // Dropped PUTC and unmapped write
    fr = frames_seen;
    wr(PUTC, 32'h77, 4'b0010, a1);
    wr(BASE + 32'h40, 32'h5a, 4'b1111, a1);
    repeat (60) @(posedge clk);
    #1;
    chk("no_frame", frames_seen, fr);
    rd(STAT, v); chk("status_unchanged", v, 32'h2);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      int r = $urandom_range(0, 9);
      if (r <= 5) begin
        wr(PUTC, $urandom, 4'($urandom_range(0, 15)), a1);
      end else if (r == 6) begin
        wr(BASE + 32'h40 + 32'($urandom_range(0, 15)) * 4, $urandom, 4'hf, a1);
      end else if (r == 7) begin
        logic [31:0] ra = BASE + 32'h24 + 32'($urandom_range(0, 7)) * 4;
        rd(ra, v); chk("nonstatus_read", v, 32'h0);
      end else begin
        repeat ($urandom_range(1, 30)) @(posedge clk);
        #1;
      end
    end
    drain();
    rd(STAT, v); chk("rand_idle_status", v, idle_status());

    // EXIT is sticky on the first write
    wr(EXIT, 32'h1, 4'hf, a1);
    chk("exit_valid", {31'b0, exit_valid}, {31'b0, m_exit});
    chk("exit_code", exit_code, m_code);
    rd(STAT, v); chk("exit_status", v, idle_status());
    wr(EXIT, 32'h5, 4'hf, a1);
    #1 chk("exit_code_sticky", exit_code, 32'h1);

    // Reset mid-frame with bytes queued
    wr(PUTC, 32'h50, 4'b0001, a0);
    wr(PUTC, 32'h51, 4'b0001, a1);
    wr(PUTC, 32'h52, 4'b0001, a1);
    while (cyc < a0 + 2 + 13) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    m_exit = 1'b0; m_code = 32'h0;
    fr = frames_seen;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset_tx", {31'b0, uart_tx}, 32'd1);
    chk("midreset_exit", {31'b0, exit_valid}, 32'd0);
    chk("midreset_code", exit_code, 32'h0);
    rd(STAT, v); chk("midreset_status", v, 32'h2);
    repeat (100) @(posedge clk);
    #1;
    chk("midreset_no_frames", frames_seen, fr);
    chk("midreset_line_idle", {31'b0, uart_tx}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
